// File: rtl/cfg_link_pkg.sv
// Shared definitions for the configuration frame link: FSM states,
// default sync bytes and address limit, and frame arithmetic helpers.
package cfg_link_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC1,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CHK,
        S_WRITE
    } state_t;

    localparam logic [7:0]  HDR0_DEFAULT     = 8'hEB;
    localparam logic [7:0]  HDR1_DEFAULT     = 8'h90;
    localparam logic [7:0]  MAX_ADDR_DEFAULT = 8'h13;
    localparam logic [15:0] TIMEOUT_DEFAULT  = 16'd5000;

    // Frame checksum: XOR of the three payload bytes.
    function automatic logic [7:0] calc_chk(input logic [7:0] addr,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
        return addr ^ dhi ^ dlo;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == '1) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cfg_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while a frame is open and
// flags the cycle that completes TIMEOUT_CYC idle cycles.
module cfg_gap_timer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd5000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    // expired fires in the cycle whose edge would bring the count to
    // TIMEOUT_CYC, so the FSM leaves exactly TIMEOUT_CYC idle cycles in.
    assign expired = enable && !clear && (count == TIMEOUT_CYC - 16'd1);

    // Idle-cycle counter, held at zero whenever cleared or disabled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: parses HDR0 HDR1 ADDR DHI DLO CHK byte
// frames and issues a single-cycle registered config write per good frame.
module cfg_frame_loader
    import cfg_link_pkg::*;
#(
    parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1        = HDR1_DEFAULT,
    parameter logic [7:0]  MAX_ADDR    = MAX_ADDR_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld_in,
    output logic        wr_out,
    output logic [7:0]  wr_addr_out,
    output logic [15:0] data_out,
    output logic        busy_out,
    output logic [15:0] frame_ok_cnt_out,
    output logic [15:0] frame_err_cnt_out
);

    state_t      state;
    logic [7:0]  addr_sh;
    logic [7:0]  dhi_sh;
    logic [7:0]  dlo_sh;
    logic        frame_open;
    logic        gap_clear;
    logic        gap_expired;

    assign busy_out   = (state != S_IDLE);
    assign frame_open = (state != S_IDLE) && (state != S_WRITE);
    assign gap_clear  = byte_vld_in || !frame_open;

    cfg_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (gap_clear),
        .enable  (frame_open),
        .expired (gap_expired)
    );

    // Frame FSM with registered write strobe, write port and counters.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= S_IDLE;
            addr_sh           <= '0;
            dhi_sh            <= '0;
            dlo_sh            <= '0;
            wr_out            <= 1'b0;
            wr_addr_out       <= '0;
            data_out          <= '0;
            frame_ok_cnt_out  <= '0;
            frame_err_cnt_out <= '0;
        end else begin
            wr_out <= 1'b0;
            if (gap_expired) begin
                state             <= S_IDLE;
                addr_sh           <= '0;
                dhi_sh            <= '0;
                dlo_sh            <= '0;
                frame_err_cnt_out <= sat_inc16(frame_err_cnt_out);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_vld_in && byte_in == HDR0) begin
                            state <= S_SYNC1;
                        end
                    end
                    S_SYNC1: begin
                        if (byte_vld_in) begin
                            if (byte_in == HDR1) begin
                                state <= S_ADDR;
                            end else if (byte_in != HDR0) begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (byte_vld_in) begin
                            addr_sh <= byte_in;
                            state   <= S_DHI;
                        end
                    end
                    S_DHI: begin
                        if (byte_vld_in) begin
                            dhi_sh <= byte_in;
                            state  <= S_DLO;
                        end
                    end
                    S_DLO: begin
                        if (byte_vld_in) begin
                            dlo_sh <= byte_in;
                            state  <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (byte_vld_in) begin
                            if (byte_in == calc_chk(addr_sh, dhi_sh, dlo_sh) &&
                                addr_sh <= MAX_ADDR) begin
                                wr_addr_out <= addr_sh;
                                data_out    <= {dhi_sh, dlo_sh};
                                state       <= S_WRITE;
                            end else begin
                                frame_err_cnt_out <= sat_inc16(frame_err_cnt_out);
                                state             <= S_IDLE;
                            end
                        end
                    end
                    S_WRITE: begin
                        wr_out           <= 1'b1;
                        frame_ok_cnt_out <= sat_inc16(frame_ok_cnt_out);
                        // A byte landing here is judged as if already in IDLE,
                        // so a next-frame HDR0 goes straight to SYNC1.
                        if (byte_vld_in && byte_in == HDR0) begin
                            state <= S_SYNC1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed testbench for cfg_frame_loader with a write scoreboard.
module tb_cfg_frame_loader;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  byte_in;
    logic        byte_vld_in;
    logic        wr_out;
    logic [7:0]  wr_addr_out;
    logic [15:0] data_out;
    logic        busy_out;
    logic [15:0] frame_ok_cnt_out;
    logic [15:0] frame_err_cnt_out;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  stim[$];
    logic [15:0] exp_ok;
    logic [15:0] exp_err;
    int          low_run = 1000;

    always #5 clk_in = ~clk_in;

    cfg_frame_loader #(
        .HDR0        (8'hEB),
        .HDR1        (8'h90),
        .MAX_ADDR    (8'h13),
        .TIMEOUT_CYC (16'd5000)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .byte_in           (byte_in),
        .byte_vld_in       (byte_vld_in),
        .wr_out            (wr_out),
        .wr_addr_out       (wr_addr_out),
        .data_out          (data_out),
        .busy_out          (busy_out),
        .frame_ok_cnt_out  (frame_ok_cnt_out),
        .frame_err_cnt_out (frame_err_cnt_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the queued bytes on consecutive cycles, then drop valid.
    task automatic send_stream();
        while (stim.size() > 0) begin
            @(negedge clk_in);
            byte_in     = stim.pop_front();
            byte_vld_in = 1'b1;
        end
        @(negedge clk_in);
        byte_vld_in = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ok_cnt"}, 32'(frame_ok_cnt_out), 32'(exp_ok));
        check({tag, "_err_cnt"}, 32'(frame_err_cnt_out), 32'(exp_err));
    endtask

    // Scoreboard: every strobe must match the oldest expected write and be
    // separated from the previous strobe by at least 5 low cycles.
    always @(negedge clk_in) begin
        if (wr_out === 1'b1) begin
            check("strobe_gap_ge5", 32'(low_run >= 5), 32'd1);
            low_run = 0;
            check("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("write_addr_data", 32'({wr_addr_out, data_out}), 32'(exp_q.pop_front()));
            end
        end else if (low_run < 1000) begin
            low_run++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in      = 1'b1;
        byte_in     = 8'h00;
        byte_vld_in = 1'b0;
        exp_ok      = 16'd0;
        exp_err     = 16'd0;
        repeat (2) @(negedge clk_in);
        check("rst_wr", 32'(wr_out), 32'd0);
        check("rst_addr", 32'(wr_addr_out), 32'h00);
        check("rst_data", 32'(data_out), 32'h0000);
        check("rst_busy", 32'(busy_out), 32'd0);
        check_counts("rst");
        rst_in = 1'b0;
        @(negedge clk_in);

        // Good frame; strobe exactly one cycle after the CHK edge.
        exp_q.push_back({8'h02, 16'h1234});
        stim = '{8'hEB, 8'h90, 8'h02, 8'h12, 8'h34, 8'h24};
        send_stream();
        check("t1_wr_before", 32'(wr_out), 32'd0);
        check("t1_busy_write", 32'(busy_out), 32'd1);
        @(negedge clk_in);
        exp_ok++;
        check("t1_wr_strobe", 32'(wr_out), 32'd1);
        check("t1_busy_after", 32'(busy_out), 32'd0);
        @(negedge clk_in);
        check("t1_wr_single", 32'(wr_out), 32'd0);
        check_counts("t1");

        // Bad checksum: rejected, write port holds the previous values.
        stim = '{8'hEB, 8'h90, 8'h02, 8'h12, 8'h34, 8'h25};
        send_stream();
        exp_err++;
        check("t2_busy", 32'(busy_out), 32'd0);
        check_counts("t2");
        repeat (3) @(negedge clk_in);
        check("t2_hold_addr", 32'(wr_addr_out), 32'h02);
        check("t2_hold_data", 32'(data_out), 32'h1234);

        // Address above limit rejected; address at limit accepted.
        stim = '{8'hEB, 8'h90, 8'h14, 8'h00, 8'h01, 8'h15};
        send_stream();
        exp_err++;
        check_counts("t3_over");
        exp_q.push_back({8'h13, 16'hABCD});
        stim = '{8'hEB, 8'h90, 8'h13, 8'hAB, 8'hCD, 8'h75};
        send_stream();
        repeat (2) @(negedge clk_in);
        exp_ok++;
        check_counts("t3_limit");

        // Gap timeout: still open after 4999 idle cycles, closed at 5000.
        stim = '{8'hEB, 8'h90, 8'h05};
        send_stream();
        repeat (4999) @(negedge clk_in);
        check("t4_busy_4999", 32'(busy_out), 32'd1);
        check_counts("t4_pre");
        @(negedge clk_in);
        exp_err++;
        check("t4_busy_5000", 32'(busy_out), 32'd0);
        check_counts("t4_post");
        exp_q.push_back({8'h07, 16'h5A3C});
        stim = '{8'hEB, 8'h90, 8'h07, 8'h5A, 8'h3C, 8'h61};
        send_stream();
        repeat (2) @(negedge clk_in);
        exp_ok++;
        check_counts("t4_next");

        // Resync on repeated HDR0, then a frame whose HDR0 lands in WRITE.
        exp_q.push_back({8'h00, 16'h0001});
        exp_q.push_back({8'h01, 16'h0203});
        stim = '{8'hEB, 8'hEB, 8'h90, 8'h00, 8'h00, 8'h01, 8'h01,
                 8'hEB, 8'h90, 8'h01, 8'h02, 8'h03, 8'h00};
        send_stream();
        repeat (2) @(negedge clk_in);
        exp_ok = exp_ok + 16'd2;
        check_counts("t5");
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

        // Junk after HDR0 drops back to IDLE without counting.
        stim = '{8'h55, 8'hEB, 8'h37};
        send_stream();
        check("t6_busy", 32'(busy_out), 32'd0);
        check_counts("t6");

        // Reset mid-frame abandons it silently.
        stim = '{8'hEB, 8'h90, 8'h03};
        send_stream();
        check("t7_busy_pre", 32'(busy_out), 32'd1);
        #2 rst_in = 1'b1;
        #1;
        exp_ok  = 16'd0;
        exp_err = 16'd0;
        check("t7_rst_busy", 32'(busy_out), 32'd0);
        check("t7_rst_wr", 32'(wr_out), 32'd0);
        check("t7_rst_addr", 32'(wr_addr_out), 32'h00);
        check("t7_rst_data", 32'(data_out), 32'h0000);
        check_counts("t7_rst");
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (8) @(negedge clk_in);
        check("t7_busy_post", 32'(busy_out), 32'd0);
        check_counts("t7_post");
        exp_q.push_back({8'h11, 16'hC0DE});
        stim = '{8'hEB, 8'h90, 8'h11, 8'hC0, 8'hDE, 8'h0F};
        send_stream();
        repeat (2) @(negedge clk_in);
        exp_ok++;
        check_counts("t7_after");

        repeat (5) @(negedge clk_in);
        check("end_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
CFG_FRAME_LOADER -- requirements
Module: cfg_frame_loader

Interface
REQ-001 SHALL have parameter HDR0, default 8'hEB, first sync byte.
REQ-002 SHALL have parameter HDR1, default 8'h90, second sync byte.
REQ-003 SHALL have parameter MAX_ADDR, default 8'h13, highest writable config address.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16'd5000, maximum idle cycles between bytes inside a frame.
REQ-005 SHALL have port clk_in, input, 1, the single clock; all logic in this one domain.
REQ-006 SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port byte_in, input, 8, received command byte.
REQ-008 SHALL have port byte_vld_in, input, 1, byte_in valid for exactly this cycle.
REQ-009 SHALL have port wr_out, output, 1, config write strobe.
REQ-010 SHALL have port wr_addr_out, output, 8, config write address.
REQ-011 SHALL have port data_out, output, 16, config write data.
REQ-012 SHALL have port busy_out, output, 1, high while a frame is in progress (any state other than IDLE).
REQ-013 SHALL have port frame_ok_cnt_out, output, 16, count of accepted frames.
REQ-014 SHALL have port frame_err_cnt_out, output, 16, count of rejected frames.

Function
REQ-015 Frame format SHALL be HDR0, HDR1, ADDR, DHI, DLO, CHK, with CHK = ADDR ^ DHI ^ DLO.
REQ-016 FSM states SHALL be IDLE, SYNC1, ADDR, DHI, DLO, CHK, WRITE; state advances only on cycles with byte_vld_in=1.
REQ-017 In IDLE: byte==HDR0 -> SYNC1; any other byte is ignored and not counted.
REQ-018 In SYNC1: byte==HDR1 -> ADDR; byte==HDR0 -> stay in SYNC1; any other byte -> IDLE, not counted.
REQ-019 ADDR, DHI and DLO SHALL each latch their byte into shadow registers and advance.
REQ-020 In CHK, valid frame (checksum match and ADDR<=MAX_ADDR) -> WRITE, with wr_addr_out/data_out loaded from the shadows in the same clock edge.
REQ-021 In CHK, checksum mismatch or ADDR>MAX_ADDR -> IDLE, frame_err_cnt_out+1, no write.
REQ-022 In WRITE, wr_out SHALL be 1 for exactly one cycle, frame_ok_cnt_out+1, then -> IDLE; wr_out is registered.
REQ-023 Latency SHALL be exactly one cycle from the clock edge that accepts CHK to wr_out=1.
REQ-024 wr_addr_out/data_out SHALL hold their last written values between writes.
REQ-025 A byte_vld_in arriving in WRITE SHALL be evaluated with IDLE rules after the write completes, so an HDR0 there is not lost.
REQ-026 Back-to-back frames SHALL always produce at least 5 low cycles of wr_out between strobes, so the receiver can count rising edges.
REQ-027 Gap timer: in SYNC1..CHK, count cycles without byte_vld_in; when the count reaches TIMEOUT_CYC -> IDLE, frame_err_cnt_out+1, shadows discarded.
REQ-028 The gap timer SHALL clear on every byte_vld_in and while in IDLE or WRITE.
REQ-029 Both counters SHALL saturate at 16'hFFFF.
REQ-030 busy_out SHALL be combinationally equal to (state != IDLE).

Reset
REQ-031 While rst_in=1, asynchronously: state=IDLE, wr_out=0, wr_addr_out=8'h00, data_out=16'h0000, both counters=0, gap timer=0, busy_out=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no write and no error count.

Structure
REQ-033 Package cfg_link_pkg SHALL hold the FSM state enum, the HDR0/HDR1 defaults, the MAX_ADDR default, and the checksum function.
REQ-034 The gap timer SHALL be one sub-module, cfg_gap_timer (inputs clear, enable; output expired at TIMEOUT_CYC).

Verification
REQ-035 Bytes EB 90 02 12 34 24 -> one wr_out pulse with addr 8'h02, data 16'h1234; ok_cnt=1, err_cnt=0.
REQ-036 Bytes EB 90 02 12 34 25 (bad CHK) -> no wr_out; err_cnt=1; busy_out=0 after CHK.
REQ-037 Bytes EB 90 14 00 01 15 (addr>MAX_ADDR) -> no wr_out; err_cnt=1.
REQ-038 Bytes EB 90 05, then 5000 idle cycles -> return to IDLE, err_cnt=1; a following valid frame is accepted normally.
REQ-039 Bytes EB EB 90 00 00 01 01 (resync on repeated HDR0), then an immediate next frame starting in the WRITE cycle -> two strobes, addr 8'h00, data 16'h0001, wr_out low between them.
REQ-040 rst_in pulsed after EB 90 03 -> all outputs return to reset values; no write occurs; the counters read 0.
